// File: rtl/fifo_rd_arbiter.sv
// fifo_rd_arbiter
// Read-side scheduler for the async FIFO, running in the read clock domain.
// A single FIFO read port is shared among NUM_REQ consumers. Grants rotate
// round-robin, and each grant covers a burst of up to MAX_BURST words. Every
// delivered word carries the index of the consumer that owns it. The output
// is a one-entry buffer. At most one read is in flight, so the block issues
// at most one read every two cycles.
module fifo_rd_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                       rd_clk,
    input  logic                       rd_rst_n,
    input  logic [NUM_REQ-1:0]         req,
    output logic [NUM_REQ-1:0]         gnt,
    input  logic                       fifo_empty,
    output logic                       fifo_rd_en,
    input  logic [DATA_W-1:0]          fifo_rd_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(NUM_REQ)-1:0] out_id,
    output logic                       busy
);

    localparam int            IW      = $clog2(NUM_REQ);
    localparam int            CW      = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);
    localparam logic [IW-1:0] ID_LAST = IW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t              state_q;
    logic [NUM_REQ-1:0]  gnt_q;
    logic [IW-1:0]       id_q;
    logic [IW-1:0]       rr_q;
    logic [CW-1:0]       cnt_q;
    logic                pend_q;
    logic                ov_q;
    logic [DATA_W-1:0]   data_q;

    logic                found_d;
    logic [IW-1:0]       pick_d;
    logic                opp;
    logic                can_issue;

    // Round-robin search: first active request at or after the pointer, wrapping
    always_comb begin
        found_d = 1'b0;
        pick_d  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found_d && req[IW'((int'(rr_q) + i) % NUM_REQ)]) begin
                found_d = 1'b1;
                pick_d  = IW'((int'(rr_q) + i) % NUM_REQ);
            end
        end
    end

    // An issue opportunity needs no read in flight and room in the output buffer.
    // The burst ends at the first opportunity on which no read can be issued.
    assign opp        = !pend_q && (!ov_q || out_ready);
    assign can_issue  = opp && (cnt_q < CNT_MAX) && req[id_q] && !fifo_empty;
    assign fifo_rd_en = (state_q == READ) && can_issue;

    // Grant FSM: IDLE picks the owner, READ runs the burst, DRAIN waits for the last word
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            id_q    <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!fifo_empty && found_d) begin
                        state_q <= READ;
                        gnt_q   <= NUM_REQ'(1) << pick_d;
                        id_q    <= pick_d;
                        cnt_q   <= '0;
                    end
                end
                READ: begin
                    if (fifo_rd_en) begin
                        cnt_q <= cnt_q + CW'(1);
                    end else if (opp) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (opp) begin
                        state_q <= IDLE;
                        gnt_q   <= '0;
                        rr_q    <= (id_q == ID_LAST) ? '0 : id_q + IW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                end
            endcase
        end
    end

    // Output buffer: capture the word the cycle after the read, hold it until it is accepted
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            pend_q <= 1'b0;
            ov_q   <= 1'b0;
            data_q <= '0;
        end else begin
            pend_q <= fifo_rd_en;
            if (pend_q) begin
                data_q <= fifo_rd_data;
                ov_q   <= 1'b1;
            end else if (ov_q && out_ready) begin
                ov_q <= 1'b0;
            end
        end
    end

    assign gnt       = gnt_q;
    assign out_valid = ov_q;
    assign out_data  = data_q;
    assign out_id    = id_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// tb_fifo_rd_arbiter
// Bench for fifo_rd_arbiter. It includes a queue-based FIFO model. A
// scoreboard holds the expected {word, owner} pairs, and a queue holds the
// expected grant sequence. It also runs a cycle table for the short
// two-word burst.
module tb_fifo_rd_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic          clk          = 1'b0;
    logic          rd_rst_n     = 1'b1;
    logic [NR-1:0] req          = '0;
    logic [NR-1:0] gnt;
    logic          fifo_empty   = 1'b1;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rd_data = '0;
    logic          out_valid;
    logic          out_ready    = 1'b0;
    logic [DW-1:0] out_data;
    logic [1:0]    out_id;
    logic          busy;

    fifo_rd_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .rd_clk      (clk),
        .rd_rst_n    (rd_rst_n),
        .req         (req),
        .gnt         (gnt),
        .fifo_empty  (fifo_empty),
        .fifo_rd_en  (fifo_rd_en),
        .fifo_rd_data(fifo_rd_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_id      (out_id),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [1:0]    id;
    } exp_t;

    typedef struct {
        logic [NR-1:0] req;
        logic          rdy;
        logic [NR-1:0] gnt;
        logic          rd_en;
        logic          ov;
        logic          busy;
        logic [DW-1:0] data;
    } vec_t;

    exp_t          sb[$];
    logic [DW-1:0] fq[$];
    logic [NR-1:0] gq[$];
    int            rd_cyc[$];
    vec_t          tbl[9];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [NR-1:0] req_n       = '0;
    logic          rdy_n       = 1'b0;
    logic [DW-1:0] rd_data_nxt = '0;

    logic [NR-1:0] s_gnt, p_gnt;
    logic          s_rd, p_rd, s_ov, p_ov, s_rdy, p_rdy, s_busy;
    logic [DW-1:0] s_data, p_data;
    logic [1:0]    s_id, p_id;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic load(input logic [DW-1:0] w, input logic [1:0] id);
        exp_t e;
        fq.push_back(w);
        e.d  = w;
        e.id = id;
        sb.push_back(e);
    endtask

    task automatic clear_model();
        fq.delete();
        sb.delete();
        gq.delete();
        rd_cyc.delete();
        rd_data_nxt = '0;
        p_gnt = '0;
        p_rd  = 1'b0;
        p_ov  = 1'b0;
        p_rdy = 1'b0;
        p_data = '0;
        p_id  = '0;
    endtask

    // One clock: drive at the falling edge, sample 1 time unit later, update the FIFO model
    task automatic step();
        exp_t e;
        @(negedge clk);
        req          = req_n;
        out_ready    = rdy_n;
        fifo_empty   = (fq.size() == 0);
        fifo_rd_data = rd_data_nxt;
        #1;
        s_gnt  = gnt;
        s_rd   = fifo_rd_en;
        s_ov   = out_valid;
        s_rdy  = out_ready;
        s_busy = busy;
        s_data = out_data;
        s_id   = out_id;
        if (fifo_empty) chk("rd_en_while_empty", 32'(s_rd), 32'd0);
        if (p_rd) chk("rd_en_back_to_back", 32'(s_rd), 32'd0);
        chk("gnt_onehot0", 32'($onehot0(s_gnt)), 32'd1);
        chk("busy_vs_gnt", 32'(s_busy), 32'(s_gnt != '0));
        if (s_gnt != '0 && p_gnt == '0) begin
            chk("gnt_expected", 32'(gq.size() != 0), 32'd1);
            if (gq.size() != 0) chk("gnt_order", 32'(s_gnt), 32'(gq.pop_front()));
        end
        if (p_ov && !p_rdy) begin
            chk("hold_valid", 32'(s_ov), 32'd1);
            chk("hold_data", 32'(s_data), 32'(p_data));
            chk("hold_id", 32'(s_id), 32'(p_id));
        end
        if (s_ov && s_rdy) begin
            chk("word_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("out_data", 32'(s_data), 32'(e.d));
                chk("out_id", 32'(s_id), 32'(e.id));
            end
        end
        if (s_rd) begin
            rd_cyc.push_back(cyc);
            if (fq.size() != 0) rd_data_nxt = fq.pop_front();
        end
        p_gnt  = s_gnt;
        p_rd   = s_rd;
        p_ov   = s_ov;
        p_rdy  = s_rdy;
        p_data = s_data;
        p_id   = s_id;
        cyc++;
    endtask

    task automatic wait_rd(input string nm);
        int n = 0;
        do begin
            step();
            n++;
        end while (!s_rd && n < 50);
        chk(nm, 32'(s_rd), 32'd1);
    endtask

    task automatic wait_ov(input string nm);
        int n = 0;
        do begin
            step();
            n++;
        end while (!s_ov && n < 50);
        chk(nm, 32'(s_ov), 32'd1);
    endtask

    task automatic run_drain(input string nm);
        int n = 0;
        do begin
            step();
            n++;
        end while (!(sb.size() == 0 && gq.size() == 0 && fq.size() == 0 && !s_busy) && n < 400);
        chk({nm, "_words_left"}, 32'(sb.size()), 32'd0);
        chk({nm, "_grants_left"}, 32'(gq.size()), 32'd0);
        chk({nm, "_busy_end"}, 32'(s_busy), 32'd0);
    endtask

    task automatic do_reset();
        rd_rst_n     = 1'b0;
        req          = '0;
        req_n        = '0;
        out_ready    = 1'b0;
        rdy_n        = 1'b0;
        fifo_empty   = 1'b1;
        fifo_rd_data = '0;
        clear_model();
        repeat (2) @(negedge clk);
        #1 rd_rst_n = 1'b1;
    endtask

    // Asynchronous reset in the middle of a burst; requests and FIFO data stay available
    task automatic mid_reset(input string nm);
        rd_rst_n = 1'b0;
        #1;
        chk({nm, "_gnt"}, 32'(gnt), 32'd0);
        chk({nm, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({nm, "_rd_en"}, 32'(fifo_rd_en), 32'd0);
        chk({nm, "_busy"}, 32'(busy), 32'd0);
        chk({nm, "_out_data"}, 32'(out_data), 32'd0);
        chk({nm, "_out_id"}, 32'(out_id), 32'd0);
        repeat (3) begin
            @(negedge clk);
            req        = 4'b1111;
            fifo_empty = 1'b0;
            #1;
            chk({nm, "_held_rd_en"}, 32'(fifo_rd_en), 32'd0);
            chk({nm, "_held_gnt"}, 32'(gnt), 32'd0);
        end
        clear_model();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] hd;
        logic [1:0]    hid;

        tbl[0] = '{4'b0001, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[1] = '{4'b0001, 1'b1, 4'b0001, 1'b1, 1'b0, 1'b1, 8'h00};
        tbl[2] = '{4'b0001, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b1, 8'h00};
        tbl[3] = '{4'b0001, 1'b1, 4'b0001, 1'b1, 1'b1, 1'b1, 8'h70};
        tbl[4] = '{4'b0001, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b1, 8'h00};
        tbl[5] = '{4'b0001, 1'b1, 4'b0001, 1'b0, 1'b1, 1'b1, 8'h71};
        tbl[6] = '{4'b0001, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b1, 8'h00};
        tbl[7] = '{4'b0001, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[8] = '{4'b0001, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h00};

        // reset state
        #2 rd_rst_n = 1'b0;
        #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_id", 32'(out_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);

        // single requester: 4-word burst, regrant itself, 2 more words
        do_reset();
        req_n = 4'b0010;
        rdy_n = 1'b1;
        for (int i = 0; i < 6; i++) load(8'hA0 + 8'(i), 2'd1);
        gq.push_back(4'b0010);
        gq.push_back(4'b0010);
        run_drain("t2");
        chk("t2_rd_count", 32'(rd_cyc.size()), 32'd6);
        if (rd_cyc.size() >= 5) begin
            for (int k = 1; k < 4; k++) chk("t2_rd_spacing", 32'(rd_cyc[k] - rd_cyc[k-1]), 32'd2);
            chk("t2_regrant_gap", 32'(rd_cyc[4] - rd_cyc[3]), 32'd5);
        end

        // reset with a read in flight; the pointer has moved to 2 beforehand
        req_n = 4'b1111;
        rdy_n = 1'b1;
        for (int i = 0; i < 3; i++) load(8'h30 + 8'(i), 2'd2);
        gq.push_back(4'b0100);
        wait_rd("t1_first_rd");
        @(posedge clk);
        #1;
        mid_reset("t1_pend");
        load(8'h40, 2'd0);
        load(8'h41, 2'd0);
        gq.push_back(4'b0001);
        req_n     = 4'b1111;
        rdy_n     = 1'b0;
        out_ready = 1'b0;
        rd_rst_n  = 1'b1;
        wait_ov("t1_valid_after_release");
        chk("t1_first_word_held", 32'(s_data), 32'h40);
        mid_reset("t1_valid");

        // all four requesting: grants rotate 0,1,2,3 with 4 words each
        do_reset();
        req_n = 4'b1111;
        rdy_n = 1'b1;
        for (int i = 0; i < 16; i++) load(8'h60 + 8'(i), 2'(i / 4));
        gq.push_back(4'b0001);
        gq.push_back(4'b0010);
        gq.push_back(4'b0100);
        gq.push_back(4'b1000);
        run_drain("t3");

        // consumer back-pressure for 5 cycles
        do_reset();
        req_n = 4'b0001;
        rdy_n = 1'b0;
        for (int i = 0; i < 4; i++) load(8'h50 + 8'(i), 2'd0);
        gq.push_back(4'b0001);
        wait_ov("t4_first_valid");
        hd  = s_data;
        hid = s_id;
        chk("t4_first_data", 32'(hd), 32'h50);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t4_stall_rd_en", 32'(s_rd), 32'd0);
            chk("t4_stall_valid", 32'(s_ov), 32'd1);
            chk("t4_stall_data", 32'(s_data), 32'(hd));
            chk("t4_stall_id", 32'(s_id), 32'(hid));
        end
        rdy_n = 1'b1;
        step();
        chk("t4_resume_rd_en", 32'(s_rd), 32'd1);
        run_drain("t4");

        // FIFO runs dry after 2 words: cycle table
        do_reset();
        load(8'h70, 2'd0);
        load(8'h71, 2'd0);
        gq.push_back(4'b0001);
        for (int i = 0; i < 9; i++) begin
            req_n = tbl[i].req;
            rdy_n = tbl[i].rdy;
            step();
            chk($sformatf("t5_gnt[%0d]", i), 32'(s_gnt), 32'(tbl[i].gnt));
            chk($sformatf("t5_rd_en[%0d]", i), 32'(s_rd), 32'(tbl[i].rd_en));
            chk($sformatf("t5_valid[%0d]", i), 32'(s_ov), 32'(tbl[i].ov));
            chk($sformatf("t5_busy[%0d]", i), 32'(s_busy), 32'(tbl[i].busy));
            if (tbl[i].ov) chk($sformatf("t5_data[%0d]", i), 32'(s_data), 32'(tbl[i].data));
        end
        chk("t5_words_left", 32'(sb.size()), 32'd0);

        // request dropped after the first read: word still delivered, grant moves on
        do_reset();
        req_n = 4'b0110;
        rdy_n = 1'b1;
        load(8'h80, 2'd1);
        for (int i = 1; i < 4; i++) load(8'h80 + 8'(i), 2'd2);
        gq.push_back(4'b0010);
        gq.push_back(4'b0100);
        wait_rd("t6_first_rd");
        req_n = 4'b0100;
        run_drain("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
